// File: rtl/sw_pe_scheduler.sv
// sw_pe_scheduler: load / ramp / strip-mined run / drain / serial max reduction for the SW PE array.
// Define SW_PERF_CNT_EN to build the cyc_total job cycle counter; otherwise cyc_total reads 0.
module sw_pe_scheduler #(
  parameter int NUM_PE          = 16,
  parameter int REF_LEN         = 64,
  parameter int QRY_LEN         = 48,
  parameter int DRAIN_CYC       = 2,
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                valid,
  output logic [$clog2(REF_LEN)-1:0]          load_addr,
  output logic                                ref_we,
  output logic                                qry_we,
  output logic                                pe_clear,
  output logic [NUM_PE-1:0]                   pe_en,
  output logic [NUM_PE*WIDTH_POS_REF-1:0]     pe_i,
  output logic [NUM_PE*WIDTH_POS_QUERY-1:0]   pe_j,
  input  logic [NUM_PE*WIDTH_SCORE-1:0]       pe_max,
  input  logic [NUM_PE*WIDTH_POS_REF-1:0]     pe_pos_ref,
  input  logic [NUM_PE*WIDTH_POS_QUERY-1:0]   pe_pos_query,
  output logic                                busy,
  output logic                                finish,
  output logic [WIDTH_SCORE-1:0]              max,
  output logic [WIDTH_POS_REF-1:0]            pos_ref,
  output logic [WIDTH_POS_QUERY-1:0]          pos_query,
  output logic [15:0]                         cyc_total
);

  localparam int WS  = WIDTH_SCORE;
  localparam int WR  = WIDTH_POS_REF;
  localparam int WQ  = WIDTH_POS_QUERY;
  localparam int AW  = $clog2(REF_LEN);
  localparam int RCW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {LOAD, RAMP, RUN, DRAIN, REDUCE, DONE} state_t;

  state_t                 state, state_n;
  logic                   accept, load_last;
  logic [RCW-1:0]         ramp_cnt, red_cnt;
  logic [DCW-1:0]         drain_cnt;
  logic [NUM_PE-1:0]      en_n;
  logic [NUM_PE*WR-1:0]   i_n;
  logic [NUM_PE*WQ-1:0]   j_n;
  logic [WS-1:0]          cand_max;
  logic [WR-1:0]          cand_ref;
  logic [WQ-1:0]          cand_qry;

  assign accept    = (state == LOAD) && valid;
  assign load_last = accept && (load_addr == AW'(REF_LEN - 1));
  assign ref_we    = accept;
  assign qry_we    = accept && (int'(load_addr) < QRY_LEN);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (load_last) state_n = RAMP;
      RAMP:    if (ramp_cnt == RCW'(NUM_PE - 1)) state_n = RUN;
      RUN:     if (en_n == '0) state_n = DRAIN;
      DRAIN:   if (drain_cnt == DCW'(DRAIN_CYC - 1)) state_n = REDUCE;
      REDUCE:  if (red_cnt == RCW'(NUM_PE - 1)) state_n = DONE;
      DONE:    state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // Per-PE advance; the ramp enables PE r+1 one edge after PE r so each PE trails its neighbour by one cycle.
  always_comb begin
    en_n = pe_en;
    i_n  = pe_i;
    j_n  = pe_j;
    for (int k = 0; k < NUM_PE; k++) begin
      if (pe_en[k]) begin
        if (int'(pe_i[k*WR +: WR]) < REF_LEN) begin
          i_n[k*WR +: WR] = pe_i[k*WR +: WR] + 1'b1;
        end else if (int'(pe_j[k*WQ +: WQ]) + NUM_PE <= QRY_LEN) begin
          i_n[k*WR +: WR] = WR'(1);
          j_n[k*WQ +: WQ] = pe_j[k*WQ +: WQ] + WQ'(NUM_PE);
        end else begin
          en_n[k]         = 1'b0;
          i_n[k*WR +: WR] = '0;
          j_n[k*WQ +: WQ] = '0;
        end
      end
      if (k + 1 <= QRY_LEN) begin
        if ((load_last && k == 0) || (state == RAMP && int'(ramp_cnt) + 1 == k)) begin
          en_n[k]         = 1'b1;
          i_n[k*WR +: WR] = WR'(1);
          j_n[k*WQ +: WQ] = WQ'(k + 1);
        end
      end
    end
  end

  always_comb begin
    cand_max = max;
    cand_ref = pos_ref;
    cand_qry = pos_query;
    for (int k = 0; k < NUM_PE; k++) begin
      if (int'(red_cnt) == k && pe_max[k*WS +: WS] > max) begin
        cand_max = pe_max[k*WS +: WS];
        cand_ref = pe_pos_ref[k*WR +: WR];
        cand_qry = pe_pos_query[k*WQ +: WQ];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_addr <= '0;
      pe_clear  <= 1'b0;
      pe_en     <= '0;
      pe_i      <= '0;
      pe_j      <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      ramp_cnt  <= '0;
      drain_cnt <= '0;
      red_cnt   <= '0;
      max       <= '0;
      pos_ref   <= '0;
      pos_query <= '0;
    end else begin
      pe_en    <= en_n;
      pe_i     <= i_n;
      pe_j     <= j_n;
      pe_clear <= load_last;
      busy     <= (state_n != LOAD);
      finish   <= (state == REDUCE) && (state_n == DONE);
      if (state != LOAD || load_last) load_addr <= '0;
      else if (accept)                load_addr <= load_addr + 1'b1;
      ramp_cnt  <= (state == RAMP)   ? ramp_cnt + 1'b1  : '0;
      drain_cnt <= (state == DRAIN)  ? drain_cnt + 1'b1 : '0;
      red_cnt   <= (state == REDUCE) ? red_cnt + 1'b1   : '0;
      // Result registers double as the running max; they hold from DONE until the next reduction starts.
      if (state == DRAIN && state_n == REDUCE) begin
        max       <= '0;
        pos_ref   <= '0;
        pos_query <= '0;
      end else if (state == REDUCE) begin
        max       <= cand_max;
        pos_ref   <= cand_ref;
        pos_query <= cand_qry;
      end
    end
  end

`ifdef SW_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_total <= '0;
    end else if (state == LOAD) begin
      if (load_last) cyc_total <= '0;
    end else if (state != DONE && cyc_total != 16'hFFFF) begin
      cyc_total <= cyc_total + 16'd1;
    end
  end
`else
  assign cyc_total = '0;
`endif

endmodule

// File: tb/tb_sw_pe_scheduler.sv
// tb_sw_pe_scheduler: randomized scoreboard bench; expected schedules and results come from
// closed-form per-PE timing and a two-pass max search, checked by a separate monitor process.
module tb_sw_pe_scheduler;
  localparam int N  = 16;
  localparam int R  = 64;
  localparam int Q  = 48;
  localparam int DC = 2;
  localparam int WS = 8;
  localparam int WR = 7;
  localparam int WQ = 6;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              reset, valid;
  logic [AW-1:0]     load_addr;
  logic              ref_we, qry_we, pe_clear, busy, finish;
  logic [N-1:0]      pe_en;
  logic [N*WR-1:0]   pe_i;
  logic [N*WQ-1:0]   pe_j;
  logic [N*WS-1:0]   pe_max_bus;
  logic [N*WR-1:0]   pe_pos_ref_bus;
  logic [N*WQ-1:0]   pe_pos_query_bus;
  logic [WS-1:0]     res_max;
  logic [WR-1:0]     res_pos_ref;
  logic [WQ-1:0]     res_pos_query;
  logic [15:0]       cyc_total;

  sw_pe_scheduler dut (
    .clk(clk), .reset(reset), .valid(valid), .load_addr(load_addr),
    .ref_we(ref_we), .qry_we(qry_we), .pe_clear(pe_clear), .pe_en(pe_en),
    .pe_i(pe_i), .pe_j(pe_j), .pe_max(pe_max_bus), .pe_pos_ref(pe_pos_ref_bus),
    .pe_pos_query(pe_pos_query_bus), .busy(busy), .finish(finish), .max(res_max),
    .pos_ref(res_pos_ref), .pos_query(res_pos_query), .cyc_total(cyc_total)
  );

  typedef struct {
    int            t0;
    int            fin_t;
    logic [WS-1:0] mx;
    logic [WR-1:0] pr;
    logic [WQ-1:0] pq;
  } exp_t;

  exp_t exp_q[$];
  int   rd     = 0;
  int   aborts = 0;
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Number of row strips PE k processes: its j values are k+1, k+1+N, ... up to Q.
  function automatic int strips(input int k);
    return (k + 1 <= Q) ? (Q - (k + 1)) / N + 1 : 0;
  endfunction

  function automatic int fin_cycle();
    int last_idle = 0;
    for (int k = 0; k < N; k++)
      if (k + strips(k) * R > last_idle) last_idle = k + strips(k) * R;
    return last_idle + DC + N;
  endfunction

  task automatic model_pe(input int t, output logic [N-1:0] en, output logic [N*WR-1:0] iv,
                          output logic [N*WQ-1:0] jv);
    en = '0; iv = '0; jv = '0;
    for (int k = 0; k < N; k++) begin
      if (t >= k && t - k < strips(k) * R) begin
        en[k]           = 1'b1;
        iv[k*WR +: WR]  = WR'((t - k) % R + 1);
        jv[k*WQ +: WQ]  = WQ'(k + 1 + N * ((t - k) / R));
      end
    end
  endtask

  // Global maximum first, then the lowest PE index that holds it; all-zero leaves positions at 0.
  task automatic model_result(output logic [WS-1:0] m, output logic [WR-1:0] pr, output logic [WQ-1:0] pq);
    int best = 0;
    for (int k = 0; k < N; k++)
      if (int'(pe_max_bus[k*WS +: WS]) > best) best = int'(pe_max_bus[k*WS +: WS]);
    m = WS'(best); pr = '0; pq = '0;
    if (best > 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (int'(pe_max_bus[k*WS +: WS]) == best) begin
          pr = pe_pos_ref_bus[k*WR +: WR];
          pq = pe_pos_query_bus[k*WQ +: WQ];
        end
      end
    end
  endtask

  function automatic bit dup_found();
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (pe_en[a] && pe_en[b] && pe_i[a*WR +: WR] == pe_i[b*WR +: WR] &&
            pe_j[a*WQ +: WQ] == pe_j[b*WQ +: WQ]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_load_addr"}, 128'(load_addr), '0);
    check({tag, "_pe_en"},     128'(pe_en), '0);
    check({tag, "_pe_i"},      128'(pe_i), '0);
    check({tag, "_pe_j"},      128'(pe_j), '0);
    check({tag, "_pe_clear"},  128'(pe_clear), '0);
    check({tag, "_busy"},      128'(busy), '0);
    check({tag, "_finish"},    128'(finish), '0);
    check({tag, "_max"},       128'(res_max), '0);
    check({tag, "_pos_ref"},   128'(res_pos_ref), '0);
    check({tag, "_pos_query"}, 128'(res_pos_query), '0);
    check({tag, "_cyc_total"}, 128'(cyc_total), '0);
    check({tag, "_writes"},    128'({ref_we, qry_we}), '0);
  endtask

  // mode 0: all zero; 1: PE3=5, PE7=9, PE12=9; 2: random with a forced tie on the maximum.
  task automatic set_pe(input int mode);
    int a, b, best;
    for (int k = 0; k < N; k++) begin
      pe_max_bus[k*WS +: WS]       = (mode == 2) ? WS'($urandom_range(0, 200)) : '0;
      pe_pos_ref_bus[k*WR +: WR]   = WR'($urandom_range(1, R));
      pe_pos_query_bus[k*WQ +: WQ] = WQ'($urandom_range(1, Q));
    end
    if (mode == 1) begin
      pe_max_bus[3*WS +: WS]  = 8'd5;
      pe_max_bus[7*WS +: WS]  = 8'd9;
      pe_max_bus[12*WS +: WS] = 8'd9;
    end else if (mode == 2) begin
      a = $urandom_range(0, N - 1);
      b = $urandom_range(0, N - 1);
      best = $urandom_range(201, 255);
      pe_max_bus[a*WS +: WS] = WS'(best);
      pe_max_bus[b*WS +: WS] = WS'(best);
    end
  endtask

  task automatic do_load(input int gap_at, input bit rnd);
    int   cnt = 0;
    int   gap_left = 3;
    int   guard = 0;
    bit   v;
    exp_t e;
    while (cnt < R && guard < 2000) begin
      @(negedge clk);
      guard++;
      check("load_addr", 128'(load_addr), 128'(cnt));
      if (cnt == gap_at && gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else if (rnd) begin
        v = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b1;
      end
      valid = v;
      #1;
      check("ref_we", 128'(ref_we), 128'(v));
      check("qry_we", 128'(qry_we), 128'(v && cnt < Q));
      if (v) begin
        cnt++;
        if (cnt == R) begin
          e.t0    = cyc + 1;
          e.fin_t = fin_cycle();
          model_result(e.mx, e.pr, e.pq);
          exp_q.push_back(e);
        end
      end
    end
    if (cnt < R) begin
      tests++; fails++;
      $display("FAIL load_timeout: accepted %0d, required %0d", cnt, R);
    end
  endtask

  task automatic wait_job(input int abort_at);
    int   idx = exp_q.size() - 1;
    int   n = 0;
    int   t;
    exp_t e = exp_q[idx];
    while (rd <= idx && n < 600) begin
      @(negedge clk);
      n++;
      t = cyc - e.t0;
      if (abort_at >= 0 && t == abort_at) begin
        valid = 1'b0;
        reset = 1'b1;
        aborts++;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b0;
        return;
      end
      valid = (t <= e.fin_t) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (t >= 0 && t <= e.fin_t) check("busy_no_write", 128'({ref_we, qry_we}), '0);
      if (t == 5) begin
        check("ramp_en5", 128'(pe_en[5]), 128'(1));
        check("ramp_i5",  128'(pe_i[5*WR +: WR]), 128'(1));
        check("ramp_j5",  128'(pe_j[5*WQ +: WQ]), 128'(6));
        check("ramp_i0",  128'(pe_i[0 +: WR]), 128'(6));
      end
      if (t == 63) check("row_end_ij0", 128'({pe_i[0 +: WR], pe_j[0 +: WQ]}), 128'({7'd64, 6'd1}));
      if (t == 64) check("row_sw_ij0",  128'({pe_i[0 +: WR], pe_j[0 +: WQ]}), 128'({7'd1, 6'd17}));
      if (t == 191) check("last_ij0",   128'({pe_i[0 +: WR], pe_j[0 +: WQ]}), 128'({7'd64, 6'd33}));
      if (t == 192) check("retire_pe0", 128'({pe_en[0], pe_i[0 +: WR], pe_j[0 +: WQ]}), '0);
    end
    if (rd <= idx) begin
      tests++; fails++;
      $display("FAIL job_timeout: no finish within %0d cycles, expected at cycle %0d", n, e.fin_t);
    end
  endtask

  // Monitor: compares the DUT's schedule every cycle and pops a scoreboard entry on finish.
  initial begin
    int            seen = 0;
    int            t;
    exp_t          e;
    logic [N-1:0]  en;
    logic [N*WR-1:0] iv;
    logic [N*WQ-1:0] jv;
    logic [15:0]   exp_cyc;
    forever begin
      @(negedge clk);
      if (aborts != seen) begin
        seen = aborts;
        if (rd < exp_q.size()) rd++;
      end else if (rd < exp_q.size()) begin
        e = exp_q[rd];
        t = cyc - e.t0;
        if (t >= 0) begin
          model_pe(t, en, iv, jv);
          check("pe_en",     128'(pe_en), 128'(en));
          check("pe_i",      128'(pe_i), 128'(iv));
          check("pe_j",      128'(pe_j), 128'(jv));
          check("pe_clear",  128'(pe_clear), 128'(t == 0));
          check("busy",      128'(busy), 128'(t <= e.fin_t));
          check("finish",    128'(finish), 128'(t == e.fin_t));
          check("unique_ij", 128'(dup_found()), '0);
          if (finish) begin
`ifdef SW_PERF_CNT_EN
            exp_cyc = (e.fin_t > 65535) ? 16'hFFFF : 16'(e.fin_t);
`else
            exp_cyc = 16'd0;
`endif
            check("result_max",       128'(res_max), 128'(e.mx));
            check("result_pos_ref",   128'(res_pos_ref), 128'(e.pr));
            check("result_pos_query", 128'(res_pos_query), 128'(e.pq));
            check("cyc_total",        128'(cyc_total), 128'(exp_cyc));
          end
          if (t > e.fin_t) begin
            check("post_load_addr", 128'(load_addr), '0);
            check("post_max_hold",  128'({res_max, res_pos_ref, res_pos_query}), 128'({e.mx, e.pr, e.pq}));
            rd++;
          end
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    valid            = 1'b0;
    pe_max_bus       = '0;
    pe_pos_ref_bus   = '0;
    pe_pos_query_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    set_pe(1);
    do_load(-1, 1'b0);
    wait_job(-1);

    set_pe(2);
    do_load(20, 1'b0);
    wait_job(-1);

    for (int n = 0; n < 3; n++) begin
      set_pe(2);
      do_load(-1, 1'b1);
      wait_job(-1);
    end

    set_pe(2);
    do_load(-1, 1'b1);
    wait_job(100);

    set_pe(0);
    do_load(-1, 1'b1);
    wait_job(-1);

    set_pe(1);
    do_load(-1, 1'b0);
    wait_job(-1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
